// File: rtl/pulse_mode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_mode_sequencer
//  Description : Steps the pulse shaper through its four waveform modes,
//                either manually (next/previous) or automatically (fixed
//                dwell per mode). Each change waits for a frame boundary
//                (optional) and is followed by a blanking gap with the
//                one-hot select forced to 0000.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_mode_sequencer #(
    parameter int unsigned DWELL_CYCLES = 50_000_000,
    parameter int unsigned GAP_CYCLES   = 16,
    parameter bit          FRAME_SYNC   = 1'b1
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       next_pls,
    input  logic       pre_pls,
    input  logic       auto_pls,
    input  logic       frame_end,
    output logic [3:0] Enable_SW,
    output logic [1:0] mode_idx,
    output logic       auto_on,
    output logic       switching
);

    // Counter widths: the dwell counter only needs to reach DWELL_CYCLES-1,
    // the gap counter only GAP_CYCLES-1.
    localparam int c_DWELL_W = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
    localparam int c_GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [c_DWELL_W-1:0] c_DWELL_LAST = c_DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [c_DWELL_W-1:0] c_DWELL_ONE  = c_DWELL_W'(1);
    localparam logic [c_DWELL_W-1:0] c_DWELL_ZERO = '0;
    localparam logic [c_GAP_W-1:0]   c_GAP_LAST   = c_GAP_W'(GAP_CYCLES - 1);
    localparam logic [c_GAP_W-1:0]   c_GAP_ONE    = c_GAP_W'(1);
    localparam logic [c_GAP_W-1:0]   c_GAP_ZERO   = '0;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_WAIT_EDGE = 2'd1,
        ST_BLANK     = 2'd2
    } state_t;

    // Registered state
    state_t               r_state;
    logic [1:0]           r_mode;
    logic [1:0]           r_target;
    logic                 r_auto_on;
    logic [c_DWELL_W-1:0] r_dwell_cnt;
    logic [c_GAP_W-1:0]   r_gap_cnt;
    logic [3:0]           r_enable_sw;
    logic                 r_switching;

    // Next-state values
    state_t               w_state_n;
    logic [1:0]           w_mode_n;
    logic [1:0]           w_target_n;
    logic                 w_auto_n;
    logic [c_DWELL_W-1:0] w_dwell_n;
    logic [c_GAP_W-1:0]   w_gap_n;
    logic [3:0]           w_enable_n;

    // Decoded requests: a simultaneous next+prev press cancels itself out.
    logic w_single_next;
    logic w_single_pre;
    logic w_tick;

    assign w_single_next = next_pls & ~pre_pls;
    assign w_single_pre  = pre_pls & ~next_pls;
    assign w_tick        = r_auto_on && (r_dwell_cnt == c_DWELL_LAST);

    // State register and registered outputs; reset aborts any pending change.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_mode      <= 2'd0;
            r_target    <= 2'd0;
            r_auto_on   <= 1'b0;
            r_dwell_cnt <= c_DWELL_ZERO;
            r_gap_cnt   <= c_GAP_ZERO;
            r_enable_sw <= 4'b0001;
            r_switching <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_mode      <= w_mode_n;
            r_target    <= w_target_n;
            r_auto_on   <= w_auto_n;
            r_dwell_cnt <= w_dwell_n;
            r_gap_cnt   <= w_gap_n;
            r_enable_sw <= w_enable_n;
            r_switching <= (w_state_n != ST_RUN);
        end
    end

    // Next-state logic: request decode, target accumulation, dwell and gap timing.
    always_comb begin
        w_state_n  = r_state;
        w_mode_n   = r_mode;
        w_target_n = r_target;
        w_auto_n   = r_auto_on ^ auto_pls;
        w_dwell_n  = c_DWELL_ZERO;
        w_gap_n    = r_gap_cnt;

        case (r_state)
            ST_RUN: begin
                // Dwell only advances while auto stays on through this cycle,
                // so switching auto on starts the count from zero next cycle.
                if (r_auto_on && w_auto_n) begin
                    w_dwell_n = r_dwell_cnt + c_DWELL_ONE;
                end
                // Manual presses win over the auto tick; the tick is just a
                // "next" so a coincident next press yields one step only.
                if (w_single_next || w_single_pre || w_tick) begin
                    if (w_single_pre) begin
                        w_target_n = r_mode - 2'd1;
                    end else begin
                        w_target_n = r_mode + 2'd1;
                    end
                    w_state_n = FRAME_SYNC ? ST_WAIT_EDGE : ST_BLANK;
                    w_dwell_n = c_DWELL_ZERO;
                    w_gap_n   = c_GAP_ZERO;
                end
            end

            ST_WAIT_EDGE: begin
                // Further presses retarget relative to the pending target.
                if (w_single_next) begin
                    w_target_n = r_target + 2'd1;
                end else if (w_single_pre) begin
                    w_target_n = r_target - 2'd1;
                end
                if (frame_end) begin
                    w_state_n = ST_BLANK;
                    w_gap_n   = c_GAP_ZERO;
                end
            end

            ST_BLANK: begin
                // Buttons are ignored here; the gap always runs to completion.
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_state_n = ST_RUN;
                    w_mode_n  = r_target;
                    w_gap_n   = c_GAP_ZERO;
                end else begin
                    w_gap_n = r_gap_cnt + c_GAP_ONE;
                end
            end

            default: begin
                w_state_n = ST_RUN;
                w_gap_n   = c_GAP_ZERO;
            end
        endcase

        // Select is blanked only while in BLANK, otherwise one-hot of the mode.
        if (w_state_n == ST_BLANK) begin
            w_enable_n = 4'b0000;
        end else begin
            w_enable_n = 4'b0001 << w_mode_n;
        end
    end

    assign Enable_SW = r_enable_sw;
    assign mode_idx  = r_mode;
    assign auto_on   = r_auto_on;
    assign switching = r_switching;

endmodule
`default_nettype wire
